bbox_locate: RTL and testbench

Per-frame bounding-box locator for the binarized fruit image. It scans the 1-bit foreground stream using the video timing strobes, tracking running min/max column and row of foreground pixels and the foreground pixel count. At each end of frame it latches the box corners and count. Its outputs drive the feature extractor's `hcount_l/r`, `vcount_l/r` inputs.

---
 rtl/bbox_locate_pkg.sv | 13 +
 rtl/bbox_locate_minmax_track.sv | 29 ++
 rtl/bbox_locate.sv | 135 +++++++++++++
 tb/tb_bbox_locate.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bbox_locate_pkg.sv
// Shared definitions for the per-frame bounding-box locator.
package bbox_locate_pkg;
  localparam int unsigned CW_DEF = 12;
  localparam int unsigned NW_DEF = 24;

  localparam logic [CW_DEF-1:0] COORD_MAX  = '1;
  localparam logic [CW_DEF-1:0] COORD_ZERO = '0;

  typedef enum logic {
    WAIT_SOF,
    SCAN
  } state_t;
endpackage

// File: rtl/bbox_locate_minmax_track.sv
// Running unsigned min/max tracker for one coordinate axis.
module minmax_track
  import bbox_locate_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          en,
  input  logic [CW-1:0] val,
  output logic [CW-1:0] min,
  output logic [CW-1:0] max
);

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      min <= '1;
      max <= '0;
    end else if (init) begin
      min <= '1;
      max <= '0;
    end else if (en) begin
      if (val < min) min <= val;
      if (val > max) max <= val;
    end
  end

endmodule

// File: rtl/bbox_locate.sv
// Per-frame bounding box and foreground count of the binarized pixel stream.
module bbox_locate
  import bbox_locate_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned NW      = NW_DEF,
  parameter int unsigned MIN_PIX = 16
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  input  logic          i_bit,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          i_de,
  output logic [CW-1:0] hcount_l,
  output logic [CW-1:0] hcount_r,
  output logic [CW-1:0] vcount_l,
  output logic [CW-1:0] vcount_r,
  output logic [NW-1:0] o_pix_cnt,
  output logic          o_valid,
  output logic          o_done
);

  state_t        state;
  logic          vs_r, de_r;
  logic          sof, eof, line_end, pix;
  logic [CW-1:0] x, y;
  logic [CW-1:0] xmin, xmax, ymin, ymax;
  logic [NW-1:0] cnt;
  logic          unused_hs;

  assign unused_hs = i_hs;

  // vs_r resets high so a frame already in progress at reset release
  // does not look like a start of frame and is never reported.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r <= 1'b1;
      de_r <= 1'b0;
    end else begin
      vs_r <= i_vs;
      de_r <= i_de;
    end
  end

  assign sof      = i_vs & ~vs_r;
  assign eof      = ~i_vs & vs_r;
  assign line_end = ~i_de & de_r;
  assign pix      = (state == SCAN) & i_vs & i_de & i_bit;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (sof) begin
      x <= '0;
      y <= '0;
    end else if (line_end) begin
      x <= '0;
      if (y != '1) y <= y + 1'b1;
    end else if (i_de) begin
      if (x != '1) x <= x + 1'b1;
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sof) begin
      cnt <= '0;
    end else if (pix && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  minmax_track #(.CW(CW)) u_track_x (
    .pixelclk (pixelclk),
    .rst_n    (rst_n),
    .init     (sof),
    .en       (pix),
    .val      (x),
    .min      (xmin),
    .max      (xmax)
  );

  minmax_track #(.CW(CW)) u_track_y (
    .pixelclk (pixelclk),
    .rst_n    (rst_n),
    .init     (sof),
    .en       (pix),
    .val      (y),
    .min      (ymin),
    .max      (ymax)
  );

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      hcount_l  <= '0;
      hcount_r  <= '0;
      vcount_l  <= '0;
      vcount_r  <= '0;
      o_pix_cnt <= '0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        WAIT_SOF: if (sof) state <= SCAN;
        SCAN: begin
          if (eof) begin
            state     <= WAIT_SOF;
            o_done    <= 1'b1;
            o_pix_cnt <= cnt;
            if (cnt >= NW'(MIN_PIX)) begin
              hcount_l <= xmin;
              hcount_r <= xmax;
              vcount_l <= ymin;
              vcount_r <= ymax;
              o_valid  <= 1'b1;
            end else begin
              hcount_l <= '0;
              hcount_r <= '0;
              vcount_l <= '0;
              vcount_r <= '0;
              o_valid  <= 1'b0;
            end
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_locate.sv
// Directed bench for bbox_locate; two instances differ only in MIN_PIX.
module tb_bbox_locate;
  localparam int CW = 12;
  localparam int NW = 24;

  logic pixelclk = 1'b0;
  logic rst_n    = 1'b0;
  logic bit_in   = 1'b0;
  logic hs       = 1'b0;
  logic vs       = 1'b0;
  logic de       = 1'b0;

  logic [CW-1:0] hl1, hr1, vl1, vr1, hl16, hr16, vl16, vr16;
  logic [NW-1:0] cnt1, cnt16;
  logic          valid1, valid16, done1, done16;
  logic [4*CW+NW:0] res1, res16;

  int unsigned done1_cnt  = 0;
  int unsigned done16_cnt = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;
  int unsigned d1, d16;

  always #5 pixelclk = ~pixelclk;

  bbox_locate #(.CW(CW), .NW(NW), .MIN_PIX(1)) dut1 (
    .pixelclk (pixelclk), .rst_n (rst_n), .i_bit (bit_in), .i_hs (hs),
    .i_vs (vs), .i_de (de),
    .hcount_l (hl1), .hcount_r (hr1), .vcount_l (vl1), .vcount_r (vr1),
    .o_pix_cnt (cnt1), .o_valid (valid1), .o_done (done1)
  );

  bbox_locate #(.CW(CW), .NW(NW), .MIN_PIX(16)) dut16 (
    .pixelclk (pixelclk), .rst_n (rst_n), .i_bit (bit_in), .i_hs (hs),
    .i_vs (vs), .i_de (de),
    .hcount_l (hl16), .hcount_r (hr16), .vcount_l (vl16), .vcount_r (vr16),
    .o_pix_cnt (cnt16), .o_valid (valid16), .o_done (done16)
  );

  assign res1  = {hl1, hr1, vl1, vr1, cnt1, valid1};
  assign res16 = {hl16, hr16, vl16, vr16, cnt16, valid16};

  always @(negedge pixelclk) begin
    if (done1)  done1_cnt++;
    if (done16) done16_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pixelclk);
      vs = 1'b0; de = 1'b0; bit_in = 1'b0; hs = 1'b0;
    end
  endtask

  // Frame: pre_idle cycles of vs low, then h rows of (2 blank + w active),
  // 2 trailing blanks, then the EOF cycle (optionally carrying a pixel).
  task automatic send_frame(input int pre_idle, input int w, input int h,
                            input int x0, input int x1, input int y0,
                            input int y1, input bit eof_pix);
    idle(pre_idle);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w + 2; c++) begin
        @(negedge pixelclk);
        vs = 1'b1;
        if (c < 2) begin
          de = 1'b0; bit_in = 1'b0; hs = (c == 0);
        end else begin
          de = 1'b1; hs = 1'b0;
          bit_in = (c - 2 >= x0) && (c - 2 <= x1) && (r >= y0) && (r <= y1);
        end
      end
    end
    repeat (2) begin
      @(negedge pixelclk);
      vs = 1'b1; de = 1'b0; bit_in = 1'b0;
    end
    @(negedge pixelclk);
    vs = 1'b0; de = eof_pix; bit_in = eof_pix;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge pixelclk);
    n_checks++;
    if (res1 !== '0) begin n_fail++; $display("FAIL reset_dut1: got %h expected 0", res1); end
    n_checks++;
    if ({done1, done16} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", {done1, done16}); end
    rst_n = 1'b1;
    idle(4);
    n_checks++;
    if (done1_cnt !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d expected 0", done1_cnt); end
  endtask

  task automatic test_single;
    d1 = done1_cnt;
    send_frame(3, 16, 8, 10, 10, 5, 5, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== {12'd10, 12'd10, 12'd5, 12'd5, 24'd1, 1'b1}) begin
      n_fail++; $display("FAIL single_dut1: got %h expected %h", res1, {12'd10, 12'd10, 12'd5, 12'd5, 24'd1, 1'b1}); end
    n_checks++;
    if (res16 !== {48'd0, 24'd1, 1'b0}) begin
      n_fail++; $display("FAIL single_dut16: got %h expected %h", res16, {48'd0, 24'd1, 1'b0}); end
    n_checks++;
    if (done1 !== 1'b1) begin n_fail++; $display("FAIL single_done_now: got %b expected 1", done1); end
    idle(3);
    n_checks++;
    if (done1_cnt !== d1 + 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d expected %0d", done1_cnt - d1, 1); end
  endtask

  task automatic test_rect;
    send_frame(3, 128, 84, 100, 119, 50, 79, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== {12'd100, 12'd119, 12'd50, 12'd79, 24'd600, 1'b1}) begin
      n_fail++; $display("FAIL rect_dut1: got %h expected %h", res1, {12'd100, 12'd119, 12'd50, 12'd79, 24'd600, 1'b1}); end
    n_checks++;
    if (res16 !== {12'd100, 12'd119, 12'd50, 12'd79, 24'd600, 1'b1}) begin
      n_fail++; $display("FAIL rect_dut16: got %h expected %h", res16, {12'd100, 12'd119, 12'd50, 12'd79, 24'd600, 1'b1}); end
    idle(3);
  endtask

  task automatic test_min_pix;
    send_frame(3, 16, 8, 1, 0, 1, 0, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== '0) begin n_fail++; $display("FAIL empty_dut1: got %h expected 0", res1); end
    n_checks++;
    if (res16 !== '0) begin n_fail++; $display("FAIL empty_dut16: got %h expected 0", res16); end
    send_frame(3, 16, 8, 2, 6, 1, 3, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res16 !== {48'd0, 24'd15, 1'b0}) begin
      n_fail++; $display("FAIL below_min_dut16: got %h expected %h", res16, {48'd0, 24'd15, 1'b0}); end
    n_checks++;
    if (res1 !== {12'd2, 12'd6, 12'd1, 12'd3, 24'd15, 1'b1}) begin
      n_fail++; $display("FAIL below_min_dut1: got %h expected %h", res1, {12'd2, 12'd6, 12'd1, 12'd3, 24'd15, 1'b1}); end
    idle(3);
  endtask

  task automatic test_reset_mid;
    d1 = done1_cnt; d16 = done16_cnt;
    fork
      send_frame(2, 16, 8, 0, 15, 0, 7, 1'b0);
      begin
        repeat (2 + 18 * 3 + 5) @(negedge pixelclk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (res1 !== '0) begin n_fail++; $display("FAIL midreset_clear: got %h expected 0", res1); end
        repeat (2) @(negedge pixelclk);
        rst_n = 1'b1;
      end
    join
    @(posedge pixelclk); #1;
    idle(3);
    n_checks++;
    if ({done1_cnt - d1, done16_cnt - d16} !== 64'd0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d/%0d expected 0/0", done1_cnt - d1, done16_cnt - d16); end
    n_checks++;
    if (res1 !== '0) begin n_fail++; $display("FAIL midreset_hold: got %h expected 0", res1); end
    send_frame(3, 16, 8, 4, 9, 2, 6, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res16 !== {12'd4, 12'd9, 12'd2, 12'd6, 24'd30, 1'b1}) begin
      n_fail++; $display("FAIL after_reset_frame: got %h expected %h", res16, {12'd4, 12'd9, 12'd2, 12'd6, 24'd30, 1'b1}); end
    idle(3);
  endtask

  task automatic test_back_to_back;
    send_frame(3, 8, 6, 3, 3, 3, 3, 1'b1);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== {12'd3, 12'd3, 12'd3, 12'd3, 24'd1, 1'b1}) begin
      n_fail++; $display("FAIL eof_pixel_ignored: got %h expected %h", res1, {12'd3, 12'd3, 12'd3, 12'd3, 24'd1, 1'b1}); end
    send_frame(0, 8, 6, 0, 0, 0, 0, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== {48'd0, 24'd1, 1'b1}) begin
      n_fail++; $display("FAIL b2b_dut1: got %h expected %h", res1, {48'd0, 24'd1, 1'b1}); end
    n_checks++;
    if (res16 !== {48'd0, 24'd1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_dut16: got %h expected %h", res16, {48'd0, 24'd1, 1'b0}); end
    idle(3);
  endtask

  task automatic test_wide_line;
    send_frame(3, 4100, 1, 4090, 4099, 0, 0, 1'b0);
    @(posedge pixelclk); #1;
    n_checks++;
    if (res1 !== {12'd4090, 12'd4095, 12'd0, 12'd0, 24'd10, 1'b1}) begin
      n_fail++; $display("FAIL wide_saturate: got %h expected %h", res1, {12'd4090, 12'd4095, 12'd0, 12'd0, 24'd10, 1'b1}); end
    n_checks++;
    if (res16 !== {48'd0, 24'd10, 1'b0}) begin
      n_fail++; $display("FAIL wide_dut16: got %h expected %h", res16, {48'd0, 24'd10, 1'b0}); end
    idle(3);
  endtask

  initial begin
    test_reset;
    test_single;
    test_rect;
    test_min_pix;
    test_reset_mid;
    test_back_to_back;
    test_wide_line;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
